uart_tx_framed: RTL and testbench

- Parametrised UART transmitter and successor to the fixed 8N1 transmitter in the sensor FPGA link.
- Serialises one data word per `has_data` request. Frame format is fixed at elaboration: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Sits between the command/response packer and the FPGA TX pin, and supports back-to-back frames with a 1-clock inter-frame gap.

---
 rtl/uart_tx_framed.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_framed.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start bit, 5-9 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK (line held low) state.
module uart_tx_framed #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    input  logic                 has_data,
    input  logic [DATA_BITS-1:0] data_to_send,
    output logic                 sending_bit,
    output logic                 is_transmitting,
    output logic                 transmission_done,
    output logic [2:0]           debug_state
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
        S_BREAK  = 3'd5,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] buf_q;
    logic                 sending_bit_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef UART_TX_BREAK_EN
    logic                 brk_q;
`endif

    logic          bit_end_d;
    logic [IW-1:0] idx_inc_d;
    logic          parity_d;

    assign bit_end_d = (cnt_q == CNT_LAST);
    assign idx_inc_d = idx_q + 1'b1;
    // Parity always comes from the word latched at acceptance.
    assign parity_d  = (PARITY_MODE == 1) ? ~(^buf_q) : (^buf_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            buf_q         <= '0;
            sending_bit_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q         <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == S_START || state_q == S_DATA ||
                state_q == S_PARITY || state_q == S_STOP) begin
                cnt_q <= bit_end_d ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    sending_bit_q <= 1'b1;
                    busy_q        <= 1'b0;
                    cnt_q         <= '0;
                    idx_q         <= '0;
`ifdef UART_TX_BREAK_EN
                    if (send_break) begin
                        state_q       <= S_BREAK;
                        sending_bit_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end else
`endif
                    if (has_data) begin
                        buf_q         <= data_to_send;
                        busy_q        <= 1'b1;
                        sending_bit_q <= 1'b0;
                        state_q       <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_d) begin
                        state_q       <= S_DATA;
                        sending_bit_q <= buf_q[0];
                        idx_q         <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end_d) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            if (HAS_PARITY) begin
                                state_q       <= S_PARITY;
                                sending_bit_q <= parity_d;
                            end else begin
                                state_q       <= S_STOP;
                                sending_bit_q <= 1'b1;
                            end
                        end else begin
                            idx_q         <= idx_inc_d;
                            sending_bit_q <= buf_q[idx_inc_d];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_d) begin
                        state_q       <= S_STOP;
                        sending_bit_q <= 1'b1;
                        idx_q         <= '0;
                    end
                end
                S_STOP: begin
                    // idx_q counts stop bits here
                    if (bit_end_d) begin
                        if (idx_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            idx_q   <= '0;
`ifdef UART_TX_BREAK_EN
                            done_q  <= !brk_q;
                            brk_q   <= 1'b0;
`else
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_inc_d;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!send_break) begin
                        state_q       <= S_STOP;
                        sending_bit_q <= 1'b1;
                        cnt_q         <= '0;
                        idx_q         <= '0;
                        brk_q         <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q       <= S_IDLE;
                    sending_bit_q <= 1'b1;
                    busy_q        <= 1'b0;
                    cnt_q         <= '0;
                    idx_q         <= '0;
                end
            endcase
        end
    end

    assign sending_bit       = sending_bit_q;
    assign is_transmitting   = busy_q;
    assign transmission_done = done_q;
    assign debug_state       = state_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four instances at CLOCKS_PER_BIT = 4 with different frame formats.
// Break scenario runs only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_framed;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hd;
    logic [7:0] din;
    logic [3:0] tx, busy, done;
    logic [2:0] dbg [4];
`ifdef UART_TX_BREAK_EN
    logic [3:0] brk;
`endif

    int errors = 0;
    int checks = 0;

    logic ln [0:127];
    logic bz [0:127];
    logic dn [0:127];
    logic ex [0:127];

    always #5 clk = ~clk;

    // Instance 0: 8N1, 1: 7 bits even, 2: 7 bits odd, 3: 8 bits two stop bits
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int DB = (gi == 1 || gi == 2) ? 7 : 8;
        localparam int PM = (gi == 1) ? 2 : ((gi == 2) ? 1 : 0);
        localparam int SB = (gi == 3) ? 2 : 1;
        uart_tx_framed #(
            .CLOCKS_PER_BIT(4),
            .DATA_BITS     (DB),
            .PARITY_MODE   (PM),
            .STOP_BITS     (SB)
        ) u_dut (
            .clock            (clk),
            .reset_n          (rst_n),
`ifdef UART_TX_BREAK_EN
            .send_break       (brk[gi]),
`endif
            .has_data         (hd[gi]),
            .data_to_send     (din[DB-1:0]),
            .sending_bit      (tx[gi]),
            .is_transmitting  (busy[gi]),
            .transmission_done(done[gi]),
            .debug_state      (dbg[gi])
        );
    end

    // Expected line level c cycles after the acceptance edge (4 clocks per bit)
    function automatic logic frame_bit(input logic [7:0] word, input int db, input int has_par,
                                       input logic par, input int c);
        int b;
        b = c / 4;
        if (c < 0) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= db) return word[b-1];
        if (has_par != 0 && b == db + 1) return par;
        return 1'b1;
    endfunction

    function automatic int first_diff(input int n);
        for (int c = 0; c < n; c++) if (ln[c] !== ex[c]) return c;
        return -1;
    endfunction

    function automatic int n_done(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) if (dn[c] === 1'b1) s++;
        return s;
    endfunction

    function automatic int n_busy(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) if (bz[c] === 1'b1) s++;
        return s;
    endfunction

    function automatic int first_done(input int n);
        for (int c = 0; c < n; c++) if (dn[c] === 1'b1) return c;
        return -1;
    endfunction

    // Sample index 0 is #1 after the acceptance edge
    task automatic capture(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            ln[c] = tx[k];
            bz[c] = busy[k];
            dn[c] = done[k];
            @(posedge clk); #1;
        end
    endtask

    task automatic accept(input int k, input logic [7:0] word);
        @(negedge clk);
        din   = word;
        hd[k] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        hd    = '0;
        din   = '0;
`ifdef UART_TX_BREAK_EN
        brk   = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (tx[k] !== 1'b1) begin errors++; $display("FAIL reset_line[%0d]: got %b want 1", k, tx[k]); end
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", k, done[k]); end
            checks++; if (dbg[k] !== 3'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d want 0", k, dbg[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_default_frame;
        int d;
        accept(0, 8'hA5);
        hd[0] = 1'b0;
        checks++; if (dbg[0] !== 3'd1) begin errors++; $display("FAIL default_start_state: got %0d want 1", dbg[0]); end
        capture(0, 48);
        for (int c = 0; c < 48; c++) ex[c] = frame_bit(8'hA5, 8, 0, 1'b0, c);
        d = first_diff(48);
        checks++; if (d !== -1) begin errors++; $display("FAIL default_line: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        checks++; if (first_done(48) !== 40) begin errors++; $display("FAIL default_done_cycle: got %0d want 40", first_done(48)); end
        checks++; if (n_done(0, 47) !== 1) begin errors++; $display("FAIL default_done_count: got %0d want 1", n_done(0, 47)); end
        checks++; if (n_busy(0, 47) !== 40 || bz[39] !== 1'b1) begin errors++; $display("FAIL default_busy: got %0d cycles want 40", n_busy(0, 47)); end
        $display("test_default_frame: word A5 done at %0d", first_done(48));
    endtask

    task automatic test_parity;
        int d;
        logic par;
        for (int k = 1; k <= 2; k++) begin
            par = (k == 1) ? 1'b0 : 1'b1;   // 0x55 in 7 bits has four ones
            accept(k, 8'h55);
            hd[k] = 1'b0;
            capture(k, 48);
            for (int c = 0; c < 48; c++) ex[c] = frame_bit(8'h55, 7, 1, par, c);
            d = first_diff(48);
            checks++; if (d !== -1) begin errors++; $display("FAIL parity_line[%0d]: first bad sample %0d got %b want %b", k, d, ln[d], ex[d]); end
            checks++; if (ln[33] !== par) begin errors++; $display("FAIL parity_bit[%0d]: got %b want %b", k, ln[33], par); end
            checks++; if (first_done(48) !== 40) begin errors++; $display("FAIL parity_done_cycle[%0d]: got %0d want 40", k, first_done(48)); end
            $display("test_parity: instance %0d parity bit %b", k, ln[33]);
        end
    endtask

    task automatic test_back_to_back;
        int d;
        int highs;
        accept(3, 8'h00);
        din = 8'hFF;
        fork
            capture(3, 100);
            begin
                repeat (50) @(posedge clk);
                #2 hd[3] = 1'b0;
            end
        join
        for (int c = 0; c < 100; c++)
            ex[c] = (c < 45) ? frame_bit(8'h00, 8, 0, 1'b0, c) : frame_bit(8'hFF, 8, 0, 1'b0, c - 45);
        d = first_diff(100);
        checks++; if (d !== -1) begin errors++; $display("FAIL b2b_line: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        highs = 0;
        for (int c = 36; c <= 44; c++) if (ln[c] === 1'b1) highs++;
        checks++; if (highs !== 9 || ln[35] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %0d high cycles want 9", highs); end
        checks++; if (first_done(100) !== 44) begin errors++; $display("FAIL b2b_first_done: got %0d want 44", first_done(100)); end
        checks++; if (ln[45] !== 1'b0 || bz[45] !== 1'b1) begin errors++; $display("FAIL b2b_restart: got line %b busy %b want 0 1", ln[45], bz[45]); end
        checks++; if (n_done(0, 99) !== 2 || dn[89] !== 1'b1) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done(0, 99)); end
        $display("test_back_to_back: done pulses %0d", n_done(0, 99));
    endtask

    task automatic test_busy_ignore;
        int d;
        accept(0, 8'hC3);
        fork
            capture(0, 60);
            begin
                repeat (3) @(posedge clk); #2 hd[0] = 1'b0;
                repeat (5) @(posedge clk); #2 begin hd[0] = 1'b1; din = 8'h3C; end
                repeat (5) @(posedge clk); #2 hd[0] = 1'b0;
                repeat (5) @(posedge clk); #2 hd[0] = 1'b1;
                repeat (5) @(posedge clk); #2 hd[0] = 1'b0;
            end
        join
        for (int c = 0; c < 60; c++) ex[c] = frame_bit(8'hC3, 8, 0, 1'b0, c);
        d = first_diff(60);
        checks++; if (d !== -1) begin errors++; $display("FAIL busy_line: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        checks++; if (n_done(0, 59) !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", n_done(0, 59)); end
        checks++; if (n_busy(0, 59) !== 40) begin errors++; $display("FAIL busy_cycles: got %0d want 40", n_busy(0, 59)); end

        accept(0, 8'h96);
        hd[0] = 1'b0;
        capture(0, 60);
        for (int c = 0; c < 60; c++) ex[c] = frame_bit(8'h96, 8, 0, 1'b0, c);
        d = first_diff(60);
        checks++; if (d !== -1) begin errors++; $display("FAIL pulse_line: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        checks++; if (n_done(0, 59) !== 1) begin errors++; $display("FAIL pulse_done_count: got %0d want 1", n_done(0, 59)); end
        $display("test_busy_ignore: frames C3 and 96 sent once each");
    endtask

    task automatic test_reset_midframe;
        int d;
        int seen;
        accept(0, 8'hF0);
        hd[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        checks++; if (tx[0] !== 1'b0) begin errors++; $display("FAIL midreset_pre_line: got %b want 0", tx[0]); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (tx[0] !== 1'b1) begin errors++; $display("FAIL midreset_line: got %b want 1", tx[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done[0] === 1'b1) seen++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) begin @(posedge clk); #1; if (done[0] === 1'b1 || tx[0] !== 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", seen); end

        accept(0, 8'h81);
        hd[0] = 1'b0;
        capture(0, 48);
        for (int c = 0; c < 48; c++) ex[c] = frame_bit(8'h81, 8, 0, 1'b0, c);
        d = first_diff(48);
        checks++; if (d !== -1) begin errors++; $display("FAIL midreset_resend: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        checks++; if (first_done(48) !== 40) begin errors++; $display("FAIL midreset_done_cycle: got %0d want 40", first_done(48)); end
        $display("test_reset_midframe: frame 81 after reset");
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        int d;
        @(negedge clk);
        din    = 8'h81;
        hd[0]  = 1'b1;
        brk[0] = 1'b1;
        @(posedge clk); #1;
        checks++; if (dbg[0] !== 3'd5) begin errors++; $display("FAIL break_state: got %0d want 5", dbg[0]); end
        fork
            capture(0, 80);
            begin
                repeat (19) @(posedge clk); #2 brk[0] = 1'b0;
                repeat (11) @(posedge clk); #2 hd[0] = 1'b0;
            end
        join
        for (int c = 0; c < 80; c++)
            ex[c] = (c < 20) ? 1'b0 : ((c < 25) ? 1'b1 : frame_bit(8'h81, 8, 0, 1'b0, c - 25));
        d = first_diff(80);
        checks++; if (d !== -1) begin errors++; $display("FAIL break_line: first bad sample %0d got %b want %b", d, ln[d], ex[d]); end
        checks++; if (n_busy(0, 19) !== 20) begin errors++; $display("FAIL break_busy: got %0d want 20", n_busy(0, 19)); end
        checks++; if (first_done(80) !== 65 || n_done(0, 79) !== 1) begin errors++; $display("FAIL break_done: got first %0d want 65", first_done(80)); end
        $display("test_break: break then frame 81");
    endtask
`endif

    initial begin
        test_reset();
        test_default_frame();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
